dcache_mem_bridge: RTL and testbench

Block-transfer bridge between the data-cache manage unit and a word-wide main memory. It accepts one cache-line request (refill or write-back) on the cache's block-level RAM port and serialises it into `BLOCK_SIZE` single-word transactions on a req/ack memory bus. It reports completion to the cache with a one-cycle `ram_ready` pulse, together with the assembled block on reads. It sits directly downstream of `cache_manage_unit`: that unit's `ram_*` outputs are this block's inputs, and vice versa.

---
 rtl/dcache_mem_pkg.sv | 24 ++
 rtl/dcache_mem_bridge.sv | 84 ++++++++
 tb/tb_dcache_mem_bridge.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dcache_mem_pkg.sv
// Shared types and default widths for the data-cache to main-memory block bridge.
package dcache_mem_pkg;

  localparam int DEF_OFFSET_WIDTH = 3;
  localparam int DEF_ADDR_WIDTH   = 30;
  localparam int DEF_DATA_WIDTH   = 32;
  localparam int DEF_BLOCK_WIDTH  = DEF_DATA_WIDTH << DEF_OFFSET_WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    RESP,
    GAP
  } bridge_state_t;

  // Word idx of a block; word i occupies bits [32i+31:32i].
  function automatic logic [DEF_DATA_WIDTH-1:0] block_word(
    input logic [DEF_BLOCK_WIDTH-1:0]  blk,
    input logic [DEF_OFFSET_WIDTH-1:0] idx
  );
    return blk[int'(idx)*DEF_DATA_WIDTH +: DEF_DATA_WIDTH];
  endfunction

endpackage

// File: rtl/dcache_mem_bridge.sv
// Serialises one cache-line refill or write-back into BLOCK_SIZE word
// transactions on a req/ack memory bus and pulses ram_ready on completion.
module dcache_mem_bridge
  import dcache_mem_pkg::*;
#(
  parameter  int OFFSET_WIDTH = DEF_OFFSET_WIDTH,
  parameter  int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter  int DATA_WIDTH   = DEF_DATA_WIDTH,
  localparam int BLOCK_SIZE   = 1 << OFFSET_WIDTH,
  localparam int BLOCK_WIDTH  = DATA_WIDTH * BLOCK_SIZE
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ram_en_in,
  input  logic                   ram_write_in,
  input  logic [ADDR_WIDTH-1:0]  ram_addr_in,
  input  logic [BLOCK_WIDTH-1:0] dc_data_wb,
  output logic                   ram_ready,
  output logic [BLOCK_WIDTH-1:0] block_from_ram,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  output logic [DATA_WIDTH-1:0]  mem_wdata,
  input  logic [DATA_WIDTH-1:0]  mem_rdata,
  input  logic                   mem_ack
);

  bridge_state_t            state_q;
  bridge_state_t            state_d;
  logic [ADDR_WIDTH-1:0]    base_q;
  logic                     wr_q;
  logic [BLOCK_WIDTH-1:0]   wb_buf;
  logic [BLOCK_WIDTH-1:0]   rd_buf;
  logic [OFFSET_WIDTH-1:0]  cnt;
  logic                     last_word;
  logic                     accept;

  assign last_word = (cnt == OFFSET_WIDTH'(BLOCK_SIZE - 1));
  assign accept    = (state_q == IDLE) && ram_en_in;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ram_en_in) state_d = XFER;
      XFER:    if (mem_ack && last_word) state_d = RESP;
      RESP:    state_d = GAP;
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Request latch and word stepping; an abort by reset discards any partial refill.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      base_q <= '0;
      wr_q   <= 1'b0;
      wb_buf <= '0;
      rd_buf <= '0;
      cnt    <= '0;
    end else if (accept) begin
      base_q <= ram_addr_in & ~ADDR_WIDTH'(BLOCK_SIZE - 1);
      wr_q   <= ram_write_in;
      wb_buf <= dc_data_wb;
      cnt    <= '0;
    end else if ((state_q == XFER) && mem_ack) begin
      if (!wr_q) rd_buf[int'(cnt)*DATA_WIDTH +: DATA_WIDTH] <= mem_rdata;
      if (!last_word) cnt <= cnt + 1'b1;
    end
  end

  // Every output decodes registered state, so ram_* inputs never reach mem_* combinationally.
  assign mem_req        = (state_q == XFER);
  assign mem_we         = mem_req & wr_q;
  assign mem_addr       = base_q | ADDR_WIDTH'(cnt);
  assign mem_wdata      = block_word(wb_buf, cnt);
  assign ram_ready      = (state_q == RESP);
  assign block_from_ram = rd_buf;

endmodule

// File: tb/tb_dcache_mem_bridge.sv
// Randomised bench for dcache_mem_bridge with a word-memory responder and a block-level reference model.
module tb_dcache_mem_bridge;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         ram_en_in = 1'b0;
  logic         ram_write_in = 1'b0;
  logic [29:0]  ram_addr_in = '0;
  logic [255:0] dc_data_wb = '0;
  logic         ram_ready;
  logic [255:0] block_from_ram;
  logic         mem_req;
  logic         mem_we;
  logic [29:0]  mem_addr;
  logic [31:0]  mem_wdata;
  logic [31:0]  mem_rdata = '0;
  logic         mem_ack = 1'b0;

  always #5 clk = ~clk;

  dcache_mem_bridge dut (
    .clk(clk), .rst(rst),
    .ram_en_in(ram_en_in), .ram_write_in(ram_write_in), .ram_addr_in(ram_addr_in),
    .dc_data_wb(dc_data_wb), .ram_ready(ram_ready), .block_from_ram(block_from_ram),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  int tests = 0;
  int fails = 0;
  int ready_cnt = 0;

  always @(negedge clk) if (ram_ready === 1'b1) ready_cnt++;

  // Word memory responder: random wait states, logs every acknowledged transaction.
  logic [31:0] mem [logic [29:0]];
  int  wait_max = 0;
  bit  force_ack = 0;
  bit  pending = 0;
  int  waits = 0;
  logic [29:0] log_addr [$];
  logic        log_we   [$];
  logic [31:0] log_wdata[$];

  function automatic logic [31:0] init_word(input logic [29:0] a);
    return {a, 2'b01} ^ 32'h5A5A_0F0F;
  endfunction

  always @(negedge clk) begin
    mem_ack = 1'b0;
    if (!rst) begin
      pending = 0;
    end else if (mem_req) begin
      if (!pending) begin
        pending = 1;
        waits = $urandom_range(wait_max, 0);
      end
      if (waits == 0) begin
        mem_ack = 1'b1;
        mem_rdata = mem.exists(mem_addr) ? mem[mem_addr] : init_word(mem_addr);
        if (mem_we) mem[mem_addr] = mem_wdata;
        log_addr.push_back(mem_addr);
        log_we.push_back(mem_we);
        log_wdata.push_back(mem_wdata);
        pending = 0;
      end else begin
        waits--;
      end
    end else begin
      pending = 0;
      if (force_ack) begin
        mem_ack = 1'b1;
        mem_rdata = $urandom;
      end
    end
  end

  // Reference model: a block request touches words base..base+7 in order.
  logic [31:0]  ref_mem [logic [29:0]];
  logic [255:0] ref_blk = '0;
  logic [29:0]  exp_addr [$];
  logic         exp_we   [$];
  logic [31:0]  exp_wdata[$];

  task automatic model_xfer(input bit wr, input logic [29:0] addr, input logic [255:0] wb);
    logic [29:0] base;
    logic [29:0] a;
    base = addr - (addr % 30'd8);
    for (int k = 0; k < 8; k++) begin
      a = base + 30'(k);
      exp_addr.push_back(a);
      exp_we.push_back(wr);
      if (wr) begin
        exp_wdata.push_back(wb[32*k +: 32]);
        ref_mem[a] = wb[32*k +: 32];
      end else begin
        exp_wdata.push_back('0);
        ref_blk[32*k +: 32] = ref_mem.exists(a) ? ref_mem[a] : init_word(a);
      end
    end
  endtask

  task automatic clear_logs();
    log_addr.delete(); log_we.delete(); log_wdata.delete();
    exp_addr.delete(); exp_we.delete(); exp_wdata.delete();
  endtask

  task automatic start_req(input bit wr, input logic [29:0] addr, input logic [255:0] wb);
    @(negedge clk);
    ram_en_in = 1'b1; ram_write_in = wr; ram_addr_in = addr; dc_data_wb = wb;
    @(posedge clk);
  endtask

  task automatic wait_ready(output bit ok);
    ok = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (ram_ready === 1'b1) ok = 1;
    end
    ram_en_in = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  function automatic logic [255:0] rand_block();
    logic [255:0] b;
    for (int k = 0; k < 8; k++) b[32*k +: 32] = $urandom;
    return b;
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if ({mem_req, mem_we, ram_ready} !== 3'b000) begin
      fails++; $display("FAIL reset_ctrl: req/we/ready=%b expected 000", {mem_req, mem_we, ram_ready});
    end
    tests++;
    if (mem_addr !== '0 || mem_wdata !== '0) begin
      fails++; $display("FAIL reset_bus: addr=%h wdata=%h expected 0", mem_addr, mem_wdata);
    end
    tests++;
    if (block_from_ram !== '0) begin
      fails++; $display("FAIL reset_block: got %h expected 0", block_from_ram);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_refill_zero_wait();
    int r0;
    logic [29:0] a;
    wait_max = 0;
    for (int k = 0; k < 8; k++) begin
      a = 30'h40 + 30'(k);
      mem[a] = 32'hA000_0000 + 32'(k);
      ref_mem[a] = 32'hA000_0000 + 32'(k);
    end
    clear_logs();
    model_xfer(0, 30'h43, '0);
    r0 = ready_cnt;
    start_req(0, 30'h43, '0);
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      tests++;
      if (mem_req !== (k <= 8)) begin
        fails++; $display("FAIL zw_req cycle %0d: got %b expected %b", k, mem_req, (k <= 8));
      end
      tests++;
      if (ram_ready !== (k == 9)) begin
        fails++; $display("FAIL zw_ready cycle %0d: got %b expected %b", k, ram_ready, (k == 9));
      end
      if (k == 9) begin
        ram_en_in = 1'b0;
        tests++;
        if (block_from_ram !== ref_blk) begin
          fails++; $display("FAIL zw_block: got %h expected %h", block_from_ram, ref_blk);
        end
      end
    end
    tests++;
    if (log_addr.size() != 8) begin
      fails++; $display("FAIL zw_count: got %0d words expected 8", log_addr.size());
    end
    for (int i = 0; i < log_addr.size() && i < 8; i++) begin
      tests++;
      if (log_addr[i] !== exp_addr[i] || log_we[i] !== 1'b0) begin
        fails++; $display("FAIL zw_word %0d: addr=%h we=%b expected addr=%h we=0", i, log_addr[i], log_we[i], exp_addr[i]);
      end
    end
    tests++;
    if (ready_cnt - r0 != 1) begin
      fails++; $display("FAIL zw_pulses: got %0d expected 1", ready_cnt - r0);
    end
  endtask

  task automatic test_writeback();
    logic [255:0] wb;
    bit ok;
    int r0;
    for (int k = 0; k < 8; k++) wb[32*k +: 32] = 32'h1111_1111 * 32'(k);
    clear_logs();
    model_xfer(1, 30'h87, wb);
    r0 = ready_cnt;
    start_req(1, 30'h87, wb);
    wait_ready(ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL wb_timeout: ram_ready=0 expected 1"); end
    tests++;
    if (log_addr.size() != 8) begin
      fails++; $display("FAIL wb_count: got %0d words expected 8", log_addr.size());
    end
    for (int i = 0; i < log_addr.size() && i < 8; i++) begin
      tests++;
      if (log_addr[i] !== exp_addr[i] || log_we[i] !== 1'b1 || log_wdata[i] !== exp_wdata[i]) begin
        fails++; $display("FAIL wb_word %0d: addr=%h we=%b data=%h expected addr=%h we=1 data=%h",
                          i, log_addr[i], log_we[i], log_wdata[i], exp_addr[i], exp_wdata[i]);
      end
    end
    tests++;
    if (block_from_ram !== ref_blk) begin
      fails++; $display("FAIL wb_block_hold: got %h expected %h", block_from_ram, ref_blk);
    end
    tests++;
    if (ready_cnt - r0 != 1) begin
      fails++; $display("FAIL wb_pulses: got %0d expected 1", ready_cnt - r0);
    end
  endtask

  task automatic test_random_waits();
    bit ok, wr;
    int r0;
    logic [29:0] addr;
    logic [255:0] wb;
    wait_max = 3;
    for (int n = 0; n < 8; n++) begin
      wr = 1'($urandom_range(1, 0));
      addr = (n % 3 == 0) ? 30'h80 + 30'($urandom_range(7, 0)) : 30'($urandom);
      wb = rand_block();
      clear_logs();
      model_xfer(wr, addr, wb);
      r0 = ready_cnt;
      start_req(wr, addr, wb);
      wait_ready(ok);
      tests++;
      if (!ok || ready_cnt - r0 != 1) begin
        fails++; $display("FAIL rnd_pulses req %0d: got %0d expected 1", n, ready_cnt - r0);
      end
      tests++;
      if (log_addr.size() != 8) begin
        fails++; $display("FAIL rnd_count req %0d: got %0d expected 8", n, log_addr.size());
      end
      for (int i = 0; i < log_addr.size() && i < 8; i++) begin
        tests++;
        if (log_addr[i] !== exp_addr[i] || log_we[i] !== exp_we[i] ||
            (exp_we[i] && log_wdata[i] !== exp_wdata[i])) begin
          fails++; $display("FAIL rnd_word %0d.%0d: addr=%h we=%b data=%h expected addr=%h we=%b data=%h",
                            n, i, log_addr[i], log_we[i], log_wdata[i], exp_addr[i], exp_we[i], exp_wdata[i]);
        end
      end
      tests++;
      if (block_from_ram !== ref_blk) begin
        fails++; $display("FAIL rnd_block req %0d: got %h expected %h", n, block_from_ram, ref_blk);
      end
    end
    wait_max = 0;
  endtask

  task automatic test_back_to_back();
    bit ok;
    int r0;
    clear_logs();
    model_xfer(0, 30'h1234_5, '0);
    model_xfer(0, 30'h2000, '0);
    r0 = ready_cnt;
    start_req(0, 30'h1234_5, '0);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k >= 9 && k <= 11) begin
        tests++;
        if (mem_req !== 1'b0 || ram_ready !== (k == 9)) begin
          fails++; $display("FAIL b2b_gap cycle %0d: req=%b ready=%b expected req=0 ready=%b", k, mem_req, ram_ready, (k == 9));
        end
      end
      if (k == 9) ram_addr_in = 30'h2000;
      if (k == 12) begin
        tests++;
        if (mem_req !== 1'b1 || mem_addr !== 30'h2000) begin
          fails++; $display("FAIL b2b_restart: req=%b addr=%h expected req=1 addr=2000", mem_req, mem_addr);
        end
      end
    end
    wait_ready(ok);
    tests++;
    if (!ok || ready_cnt - r0 != 2) begin
      fails++; $display("FAIL b2b_pulses: got %0d expected 2", ready_cnt - r0);
    end
    tests++;
    if (log_addr.size() != 16) begin
      fails++; $display("FAIL b2b_count: got %0d words expected 16", log_addr.size());
    end
    for (int i = 0; i < log_addr.size() && i < 16; i++) begin
      tests++;
      if (log_addr[i] !== exp_addr[i]) begin
        fails++; $display("FAIL b2b_word %0d: addr=%h expected %h", i, log_addr[i], exp_addr[i]);
      end
    end
    tests++;
    if (block_from_ram !== ref_blk) begin
      fails++; $display("FAIL b2b_block: got %h expected %h", block_from_ram, ref_blk);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int r0;
    wait_max = 0;
    start_req(0, 30'h503, '0);
    repeat (5) @(negedge clk);
    tests++;
    if (mem_req !== 1'b1 || mem_addr !== 30'h504) begin
      fails++; $display("FAIL rmid_word4: req=%b addr=%h expected req=1 addr=504", mem_req, mem_addr);
    end
    rst = 1'b0;
    ram_en_in = 1'b0;
    #1;
    tests++;
    if ({mem_req, mem_we, ram_ready} !== 3'b000 || mem_addr !== '0 || mem_wdata !== '0 || block_from_ram !== '0) begin
      fails++; $display("FAIL rmid_clear: req=%b we=%b ready=%b addr=%h wdata=%h blk=%h expected all 0",
                        mem_req, mem_we, ram_ready, mem_addr, mem_wdata, block_from_ram);
    end
    ref_blk = '0;
    r0 = ready_cnt;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (12) @(negedge clk);
    tests++;
    if (ready_cnt != r0 || mem_req !== 1'b0) begin
      fails++; $display("FAIL rmid_abort: pulses=%0d req=%b expected 0 and 0", ready_cnt - r0, mem_req);
    end
    clear_logs();
    model_xfer(0, 30'h503, '0);
    start_req(0, 30'h503, '0);
    wait_ready(ok);
    tests++;
    if (!ok || ready_cnt - r0 != 1 || log_addr.size() != 8) begin
      fails++; $display("FAIL rmid_retry: pulses=%0d words=%0d expected 1 and 8", ready_cnt - r0, log_addr.size());
    end
    tests++;
    if (block_from_ram !== ref_blk) begin
      fails++; $display("FAIL rmid_block: got %h expected %h", block_from_ram, ref_blk);
    end
  endtask

  task automatic test_spurious();
    bit ok;
    int r0;
    force_ack = 1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      tests++;
      if (mem_req !== 1'b0 || block_from_ram !== ref_blk) begin
        fails++; $display("FAIL spur_idle %0d: req=%b blk=%h expected req=0 blk=%h", k, mem_req, block_from_ram, ref_blk);
      end
    end
    force_ack = 0;
    @(negedge clk);
    clear_logs();
    model_xfer(0, 30'h7FA, '0);
    r0 = ready_cnt;
    start_req(0, 30'h7FA, '0);
    repeat (2) @(negedge clk);
    ram_addr_in = 30'h3FF000; ram_write_in = 1'b1; dc_data_wb = rand_block();
    wait_ready(ok);
    tests++;
    if (!ok || ready_cnt - r0 != 1 || log_addr.size() != 8) begin
      fails++; $display("FAIL spur_xfer: pulses=%0d words=%0d expected 1 and 8", ready_cnt - r0, log_addr.size());
    end
    for (int i = 0; i < log_addr.size() && i < 8; i++) begin
      tests++;
      if (log_addr[i] !== exp_addr[i] || log_we[i] !== 1'b0) begin
        fails++; $display("FAIL spur_word %0d: addr=%h we=%b expected addr=%h we=0", i, log_addr[i], log_we[i], exp_addr[i]);
      end
    end
    tests++;
    if (block_from_ram !== ref_blk) begin
      fails++; $display("FAIL spur_block: got %h expected %h", block_from_ram, ref_blk);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_refill_zero_wait();
    test_writeback();
    test_random_waits();
    test_back_to_back();
    test_reset_mid();
    test_spurious();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
